// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the datapath.
// Runs fetch T0-T2, then a decode cycle, then executes the states for
// the decoded instruction: R-type ALU, addi, ld, st, br, nop and halt.
// Outputs are registered from the state being entered. Two outputs are
// qualified by live inputs: PCin in branch T6 (con_ff) and the illegal
// pulse in decode (ir).
module control_sequencer #(
    parameter int         MEM_WAIT  = 0,
    parameter logic [4:0] ALU_ADD   = 5'd3,
    parameter logic [4:0] ALU_SUB   = 5'd4,
    parameter logic [4:0] ALU_AND   = 5'd9,
    parameter logic [4:0] ALU_OR    = 5'd10,
    parameter logic [4:0] ALU_INCPC = 5'd14,
    parameter logic [4:0] ALU_BRADD = 5'd15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic [4:0]  Control_Signals,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        halted,
    output logic        illegal
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Register load enable bits
    localparam int EN_Z   = 18;
    localparam int EN_Y   = 19;
    localparam int EN_PC  = 20;
    localparam int EN_MDR = 21;
    localparam int EN_IR  = 24;
    localparam int EN_MAR = 25;
    localparam int EN_CON = 27;
    // Bus driver select bits
    localparam int BS_ZLO = 19;
    localparam int BS_PC  = 20;
    localparam int BS_MDR = 21;
    localparam int BS_C   = 23;

    // Wait counter: holds a memory-access state for MEM_WAIT extra cycles
    localparam int              CW        = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0]   WAIT_LOAD = CW'(MEM_WAIT);
    localparam logic            NO_WAIT   = (MEM_WAIT == 0);

    typedef enum logic [4:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC,
        S_R3, S_R4, S_I4, S_R5,
        S_M3, S_M4, S_M5, S_LD6, S_LD7, S_ST6, S_ST7,
        S_BR3, S_BR4, S_BR5, S_BR6,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [31:0] en;
        logic [31:0] bus;
        logic [4:0]  alu;
        logic        md_read, read_ram, write_ram;
        logic        gra, grb, grc, rin, rout, baout;
        logic        halted;
    } ctrl_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    opc_q;
    ctrl_t         ctrl_q;
    logic [4:0]    opcode;
    logic          unused_ir;

    assign opcode    = ir[31:27];
    // Operand fields belong to the datapath; only the opcode steers sequencing
    assign unused_ir = ^ir[26:0];

    function automatic logic [4:0] alu_code(input logic [4:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic is_defined(input logic [4:0] opc);
        return opc inside {OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                           OP_ADDI, OP_BR, OP_NOP, OP_HALT};
    endfunction

    // Control word for a state; pc_last marks the final cycle of fetch T1
    function automatic ctrl_t ctrl_for(input state_t s, input logic pc_last,
                                       input logic [4:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            S_F0:   begin c.bus[BS_PC] = 1'b1; c.en[EN_MAR] = 1'b1;
                          c.alu = ALU_INCPC; c.en[EN_Z] = 1'b1; end
            S_F1:   begin c.bus[BS_ZLO] = 1'b1; c.en[EN_MDR] = 1'b1;
                          c.md_read = 1'b1; c.read_ram = 1'b1; c.en[EN_PC] = pc_last; end
            S_F2:   begin c.bus[BS_MDR] = 1'b1; c.en[EN_IR] = 1'b1; end
            S_R3:   begin c.grb = 1'b1; c.rout = 1'b1; c.en[EN_Y] = 1'b1; end
            S_R4:   begin c.grc = 1'b1; c.rout = 1'b1; c.alu = alu_code(opc); c.en[EN_Z] = 1'b1; end
            S_I4,
            S_M4:   begin c.bus[BS_C] = 1'b1; c.alu = ALU_ADD; c.en[EN_Z] = 1'b1; end
            S_R5:   begin c.bus[BS_ZLO] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            S_M3:   begin c.grb = 1'b1; c.baout = 1'b1; c.en[EN_Y] = 1'b1; end
            S_M5:   begin c.bus[BS_ZLO] = 1'b1; c.en[EN_MAR] = 1'b1; end
            S_LD6:  begin c.md_read = 1'b1; c.read_ram = 1'b1; c.en[EN_MDR] = 1'b1; end
            S_LD7:  begin c.bus[BS_MDR] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            S_ST6:  begin c.gra = 1'b1; c.rout = 1'b1; c.en[EN_MDR] = 1'b1; end
            S_ST7:  c.write_ram = 1'b1;
            S_BR3:  begin c.gra = 1'b1; c.rout = 1'b1; c.en[EN_CON] = 1'b1; end
            S_BR4:  begin c.bus[BS_PC] = 1'b1; c.en[EN_Y] = 1'b1; end
            S_BR5:  begin c.bus[BS_C] = 1'b1; c.alu = ALU_BRADD; c.en[EN_Z] = 1'b1; end
            S_BR6:  c.bus[BS_ZLO] = 1'b1;
            S_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Sequencer: next state, wait counter, latched opcode and registered outputs
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            opc_q  <= '0;
            ctrl_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (run) begin
                    state <= S_F0; ctrl_q <= ctrl_for(S_F0, 1'b0, opc_q);
                end
                S_F0: begin
                    state <= S_F1; cnt <= WAIT_LOAD; ctrl_q <= ctrl_for(S_F1, NO_WAIT, opc_q);
                end
                S_F1: if (cnt != '0) begin
                    cnt <= cnt - CW'(1); ctrl_q <= ctrl_for(S_F1, cnt == CW'(1), opc_q);
                end else begin
                    state <= S_F2; ctrl_q <= ctrl_for(S_F2, 1'b0, opc_q);
                end
                S_F2: begin state <= S_DEC; ctrl_q <= '0; end
                S_DEC: begin
                    opc_q <= opcode;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            state <= S_R3; ctrl_q <= ctrl_for(S_R3, 1'b0, opcode);
                        end
                        OP_LD, OP_ST: begin state <= S_M3; ctrl_q <= ctrl_for(S_M3, 1'b0, opcode); end
                        OP_BR:   begin state <= S_BR3; ctrl_q <= ctrl_for(S_BR3, 1'b0, opcode); end
                        OP_HALT: begin state <= S_HALT; ctrl_q <= ctrl_for(S_HALT, 1'b0, opcode); end
                        default: begin state <= S_F0; ctrl_q <= ctrl_for(S_F0, 1'b0, opcode); end
                    endcase
                end
                S_R3: if (opc_q == OP_ADDI) begin
                    state <= S_I4; ctrl_q <= ctrl_for(S_I4, 1'b0, opc_q);
                end else begin
                    state <= S_R4; ctrl_q <= ctrl_for(S_R4, 1'b0, opc_q);
                end
                S_R4, S_I4: begin state <= S_R5; ctrl_q <= ctrl_for(S_R5, 1'b0, opc_q); end
                S_R5:  begin state <= S_F0; ctrl_q <= ctrl_for(S_F0, 1'b0, opc_q); end
                S_M3:  begin state <= S_M4; ctrl_q <= ctrl_for(S_M4, 1'b0, opc_q); end
                S_M4:  begin state <= S_M5; ctrl_q <= ctrl_for(S_M5, 1'b0, opc_q); end
                S_M5: if (opc_q == OP_ST) begin
                    state <= S_ST6; ctrl_q <= ctrl_for(S_ST6, 1'b0, opc_q);
                end else begin
                    state <= S_LD6; cnt <= WAIT_LOAD; ctrl_q <= ctrl_for(S_LD6, 1'b0, opc_q);
                end
                S_LD6: if (cnt != '0) cnt <= cnt - CW'(1);
                       else begin state <= S_LD7; ctrl_q <= ctrl_for(S_LD7, 1'b0, opc_q); end
                S_LD7: begin state <= S_F0; ctrl_q <= ctrl_for(S_F0, 1'b0, opc_q); end
                S_ST6: begin state <= S_ST7; cnt <= WAIT_LOAD; ctrl_q <= ctrl_for(S_ST7, 1'b0, opc_q); end
                S_ST7: if (cnt != '0) cnt <= cnt - CW'(1);
                       else begin state <= S_F0; ctrl_q <= ctrl_for(S_F0, 1'b0, opc_q); end
                S_BR3: begin state <= S_BR4; ctrl_q <= ctrl_for(S_BR4, 1'b0, opc_q); end
                S_BR4: begin state <= S_BR5; ctrl_q <= ctrl_for(S_BR5, 1'b0, opc_q); end
                S_BR5: begin state <= S_BR6; ctrl_q <= ctrl_for(S_BR6, 1'b0, opc_q); end
                S_BR6: begin state <= S_F0; ctrl_q <= ctrl_for(S_F0, 1'b0, opc_q); end
                S_HALT: state <= S_HALT;
                default: begin state <= S_IDLE; ctrl_q <= '0; end
            endcase
        end
    end

    // Input-qualified outputs: branch PCin on con_ff, decode-cycle illegal pulse
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        enable = ctrl_q.en;
        if (state == S_BR6 && con_ff) enable[EN_PC] = 1'b1;
        illegal = (state == S_DEC) && !is_defined(opcode);
    end

    assign busSelect       = ctrl_q.bus;
    assign Control_Signals = ctrl_q.alu;
    assign MD_Read         = ctrl_q.md_read;
    assign ReadRAM         = ctrl_q.read_ram;
    assign WriteRAM        = ctrl_q.write_ram;
    assign Gra             = ctrl_q.gra;
    assign Grb             = ctrl_q.grb;
    assign Grc             = ctrl_q.grc;
    assign Rin             = ctrl_q.rin;
    assign Rout            = ctrl_q.rout;
    assign BAout           = ctrl_q.baout;
    assign halted          = ctrl_q.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: two sequencers (MEM_WAIT=0 and MEM_WAIT=2) are run
// through directed and random instruction streams. A per-instruction table
// of expected control words, built from the instruction rules, is compared
// cycle by cycle against the full output bundle.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic        run     [2];
    logic [31:0] ir      [2];
    logic        con_ff  [2];
    logic [31:0] enable  [2];
    logic [31:0] bus_sel [2];
    logic [4:0]  cs      [2];
    logic        md_read [2], read_ram [2], write_ram [2];
    logic        gra [2], grb [2], grc [2], rin [2], rout [2], baout [2];
    logic        halted [2], illegal [2];
    logic [79:0] obs_vec [2];

    int total = 0;
    int bad   = 0;

    control_sequencer #(.MEM_WAIT(0)) u_dut0 (
        .clk(clk), .clr(clr), .run(run[0]), .ir(ir[0]), .con_ff(con_ff[0]),
        .enable(enable[0]), .busSelect(bus_sel[0]), .Control_Signals(cs[0]),
        .MD_Read(md_read[0]), .ReadRAM(read_ram[0]), .WriteRAM(write_ram[0]),
        .Gra(gra[0]), .Grb(grb[0]), .Grc(grc[0]), .Rin(rin[0]), .Rout(rout[0]),
        .BAout(baout[0]), .halted(halted[0]), .illegal(illegal[0]));

    control_sequencer #(.MEM_WAIT(2)) u_dut1 (
        .clk(clk), .clr(clr), .run(run[1]), .ir(ir[1]), .con_ff(con_ff[1]),
        .enable(enable[1]), .busSelect(bus_sel[1]), .Control_Signals(cs[1]),
        .MD_Read(md_read[1]), .ReadRAM(read_ram[1]), .WriteRAM(write_ram[1]),
        .Gra(gra[1]), .Grb(grb[1]), .Grc(grc[1]), .Rin(rin[1]), .Rout(rout[1]),
        .BAout(baout[1]), .halted(halted[1]), .illegal(illegal[1]));

    assign obs_vec[0] = {enable[0], bus_sel[0], cs[0], md_read[0], read_ram[0], write_ram[0],
                         gra[0], grb[0], grc[0], rin[0], rout[0], baout[0], halted[0], illegal[0]};
    assign obs_vec[1] = {enable[1], bus_sel[1], cs[1], md_read[1], read_ram[1], write_ram[1],
                         gra[1], grb[1], grc[1], rin[1], rout[1], baout[1], halted[1], illegal[1]};

    // Enables and bus selects as bit masks
    localparam logic [31:0] E_Z = 32'h1 << 18, E_Y = 32'h1 << 19, E_PC = 32'h1 << 20;
    localparam logic [31:0] E_MDR = 32'h1 << 21, E_IR = 32'h1 << 24, E_MAR = 32'h1 << 25;
    localparam logic [31:0] E_CON = 32'h1 << 27;
    localparam logic [31:0] B_ZLO = 32'h1 << 19, B_PC = 32'h1 << 20, B_MDR = 32'h1 << 21;
    localparam logic [31:0] B_C = 32'h1 << 23;
    // Single-bit controls, packed in output-bundle order
    localparam logic [10:0] F_MRD = 11'h400, F_RR = 11'h200, F_WR = 11'h100, F_GRA = 11'h080;
    localparam logic [10:0] F_GRB = 11'h040, F_GRC = 11'h020, F_RIN = 11'h010, F_ROUT = 11'h008;
    localparam logic [10:0] F_BA = 11'h004, F_HALT = 11'h002, F_ILL = 11'h001;

    logic [79:0] exp_q [$];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [79:0] mk(input logic [31:0] en, input logic [31:0] bs,
                                       input logic [4:0] c, input logic [10:0] f);
        return {en, bs, c, f};
    endfunction

    task automatic push(input logic [79:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Reference: control-word sequence of one instruction, from T0 onwards
    task automatic build(input int w, input logic [4:0] opc, input logic cf);
        logic defined;
        exp_q.delete();
        defined = opc inside {5'd0, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd18, 5'd26, 5'd27};
        push(mk(E_MAR | E_Z, B_PC, 5'd14, 11'h0), 1);
        push(mk(E_MDR, B_ZLO, 5'd0, F_MRD | F_RR), w);
        push(mk(E_MDR | E_PC, B_ZLO, 5'd0, F_MRD | F_RR), 1);
        push(mk(E_IR, B_MDR, 5'd0, 11'h0), 1);
        push(mk(32'h0, 32'h0, 5'd0, defined ? 11'h0 : F_ILL), 1);
        case (opc)
            5'd3, 5'd4, 5'd9, 5'd10: begin
                push(mk(E_Y, 32'h0, 5'd0, F_GRB | F_ROUT), 1);
                push(mk(E_Z, 32'h0, (opc == 5'd3) ? 5'd3 : (opc == 5'd4) ? 5'd4 :
                        (opc == 5'd9) ? 5'd9 : 5'd10, F_GRC | F_ROUT), 1);
                push(mk(32'h0, B_ZLO, 5'd0, F_GRA | F_RIN), 1);
            end
            5'd11: begin
                push(mk(E_Y, 32'h0, 5'd0, F_GRB | F_ROUT), 1);
                push(mk(E_Z, B_C, 5'd3, 11'h0), 1);
                push(mk(32'h0, B_ZLO, 5'd0, F_GRA | F_RIN), 1);
            end
            5'd0, 5'd2: begin
                push(mk(E_Y, 32'h0, 5'd0, F_GRB | F_BA), 1);
                push(mk(E_Z, B_C, 5'd3, 11'h0), 1);
                push(mk(E_MAR, B_ZLO, 5'd0, 11'h0), 1);
                if (opc == 5'd0) begin
                    push(mk(E_MDR, 32'h0, 5'd0, F_MRD | F_RR), 1 + w);
                    push(mk(32'h0, B_MDR, 5'd0, F_GRA | F_RIN), 1);
                end else begin
                    push(mk(E_MDR, 32'h0, 5'd0, F_GRA | F_ROUT), 1);
                    push(mk(32'h0, 32'h0, 5'd0, F_WR), 1 + w);
                end
            end
            5'd18: begin
                push(mk(E_CON, 32'h0, 5'd0, F_GRA | F_ROUT), 1);
                push(mk(E_Y, B_PC, 5'd0, 11'h0), 1);
                push(mk(E_Z, B_C, 5'd15, 11'h0), 1);
                push(mk(cf ? E_PC : 32'h0, B_ZLO, 5'd0, 11'h0), 1);
            end
            5'd27: push(mk(32'h0, 32'h0, 5'd0, F_HALT), 20);
            default: ;
        endcase
    endtask

    // Runs one instruction on DUT d from its T0 (called at a falling edge).
    // lim > 0 stops right after the lim-th cycle's check.
    task automatic run_instr(input int d, input logic [31:0] word, input logic cf, input int lim);
        ir[d]     = word;
        con_ff[d] = cf;
        build(d ? 2 : 0, word[31:27], cf);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("d%0d op%b cf%0d cyc%0d", d, word[31:27], cf, i), obs_vec[d], exp_q[i]);
            if (i + 1 == lim) return;
            run[d] = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run_program(input int d);
        logic [4:0] opc;
        logic [4:0] dir_ops [10] = '{5'd18, 5'd18, 5'd0, 5'd2, 5'd11, 5'd4, 5'd9, 5'd10, 5'd26, 5'd31};
        int w;
        w = d ? 2 : 0;
        run[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d idle%0d", d, i), obs_vec[d], 80'h0);
            @(negedge clk);
        end
        run[d] = 1'b1;
        @(negedge clk);
        run_instr(d, 32'h1900_0000, 1'b0, 0);
        for (int i = 0; i < 10; i++)
            run_instr(d, {dir_ops[i], 27'($urandom)}, (i == 0), 0);
        for (int i = 0; i < 20; i++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'd27) opc = 5'd26;
            run_instr(d, {opc, 27'($urandom)}, 1'($urandom), 0);
        end
        run_instr(d, {5'd27, 27'($urandom)}, 1'b0, 0);
        // Leave halt only through clr; recovery goes IDLE then T0
        clr = 1'b0;
        #1 check($sformatf("d%0d clr_halt", d), obs_vec[d], 80'h0);
        @(negedge clk);
        clr = 1'b1; run[d] = 1'b1;
        #1 check($sformatf("d%0d idle_rel", d), obs_vec[d], 80'h0);
        @(negedge clk);
        // clr mid-instruction, during ld T4
        run_instr(d, {5'd0, 27'($urandom)}, 1'b0, 6 + w);
        #2 clr = 1'b0;
        #1 check($sformatf("d%0d clr_ld_t4", d), obs_vec[d], 80'h0);
        @(negedge clk);
        clr = 1'b1; run[d] = 1'b1;
        #1 check($sformatf("d%0d idle_rel2", d), obs_vec[d], 80'h0);
        @(negedge clk);
        run_instr(d, 32'h1900_0000, 1'b0, 0);
    endtask

    initial begin
        clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            run[d] = 1'b0; ir[d] = '0; con_ff[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst d0", obs_vec[0], 80'h0);
        check("rst d1", obs_vec[1], 80'h0);
        clr = 1'b1;
        @(negedge clk);
        run_program(0);
        run[0] = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        run_program(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=stalled want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
